// File: rtl/snitch_hwpe_arb_pkg.sv
// Shared types and helpers for the HWPE TCDM round-robin arbiter.
package snitch_hwpe_arb_pkg;

  typedef logic [31:0] perf_cnt_t;
  localparam perf_cnt_t PerfCntMax = 32'hFFFF_FFFF;

  // Requester index width; at least one bit even for degenerate counts.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// In-order ID queue: port-compatible subset of common_cells fifo_v3 (no fall-through).
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PtrW-1:0]                  wr_q, rd_q;
  logic [PtrW:0]                    cnt_q;
  logic                             do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/snitch_hwpe_rr_sel.sv
// Round-robin winner selection with a lock that holds the presented index while stalled.
module snitch_hwpe_rr_sel
  import snitch_hwpe_arb_pkg::*;
#(
  parameter int unsigned NrReq = 2,
  parameter int unsigned IdxW  = idx_width(NrReq)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [NrReq-1:0] req_i,
  input  logic             stall_i,
  input  logic             hs_i,
  output logic             valid_o,
  output logic [NrReq-1:0] onehot_o,
  output logic [IdxW-1:0]  idx_o
);

  logic [IdxW-1:0] rr_q, lock_idx_q, rr_idx;
  logic            lock_q, rr_found;

  // First requester at or above the pointer, else first from index 0.
  always_comb begin
    rr_idx   = rr_q;
    rr_found = 1'b0;
    for (int unsigned j = 0; j < NrReq; j++) begin
      if (!rr_found && req_i[j] && (IdxW'(j) >= rr_q)) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(j);
      end
    end
    for (int unsigned j = 0; j < NrReq; j++) begin
      if (!rr_found && req_i[j]) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(j);
      end
    end
  end

  assign idx_o    = lock_q ? lock_idx_q : rr_idx;
  assign valid_o  = lock_q ? req_i[lock_idx_q] : rr_found;
  assign onehot_o = valid_o ? (NrReq'(1) << idx_o) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (clear_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= stall_i;
      if (stall_i) lock_idx_q <= idx_o;
      if (hs_i) rr_q <= (idx_o == IdxW'(NrReq - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/snitch_hwpe_tcdm_arbiter.sv
// Round-robin arbiter sharing one HWPE TCDM port; in-order ID queue routes responses.
// Optional perf counters: define SNITCH_HWPE_TCDM_ARB_PERF_EN.
module snitch_hwpe_tcdm_arbiter
  import snitch_hwpe_arb_pkg::*;
#(
  parameter int unsigned NrReq          = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 256,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  clear_i,
  input  logic [NrReq-1:0]                      in_req_i,
  output logic [NrReq-1:0]                      in_gnt_o,
  input  logic [NrReq-1:0][AddrWidth-1:0]       in_add_i,
  input  logic [NrReq-1:0]                      in_wen_i,
  input  logic [NrReq-1:0][DataWidth/8-1:0]     in_be_i,
  input  logic [NrReq-1:0][DataWidth-1:0]       in_data_i,
  output logic [NrReq-1:0]                      in_r_valid_o,
  output logic [DataWidth-1:0]                  in_r_data_o,
  output logic                                  out_req_o,
  input  logic                                  out_gnt_i,
  output logic [AddrWidth-1:0]                  out_add_o,
  output logic                                  out_wen_o,
  output logic [DataWidth/8-1:0]                out_be_o,
  output logic [DataWidth-1:0]                  out_data_o,
  input  logic                                  out_r_valid_i,
  input  logic [DataWidth-1:0]                  out_r_data_i,
  output logic                                  err_o,
  output perf_cnt_t [NrReq-1:0]                 perf_gnt_o,
  output perf_cnt_t [NrReq-1:0]                 perf_stall_o
);

  localparam int unsigned IdxW = idx_width(NrReq);
  typedef logic [IdxW-1:0] idx_t;

  logic             any_req, hs, stall, pop;
  logic             q_full, q_empty;
  logic [NrReq-1:0] win_oh;
  idx_t             win_idx, head;
  logic             err_q;

  snitch_hwpe_rr_sel #(
    .NrReq (NrReq),
    .IdxW  (IdxW)
  ) i_rr_sel (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .req_i    (in_req_i),
    .stall_i  (stall),
    .hs_i     (hs),
    .valid_o  (any_req),
    .onehot_o (win_oh),
    .idx_o    (win_idx)
  );

  // Full queue blocks the request outright; a same-cycle pop does not free a slot.
  assign out_req_o = any_req & ~q_full & ~clear_i;
  assign hs        = out_req_o & out_gnt_i;
  assign stall     = out_req_o & ~out_gnt_i;
  assign in_gnt_o  = win_oh & {NrReq{hs}};

  assign out_add_o  = any_req ? in_add_i[win_idx]  : '0;
  assign out_wen_o  = any_req ? in_wen_i[win_idx]  : 1'b0;
  assign out_be_o   = any_req ? in_be_i[win_idx]   : '0;
  assign out_data_o = any_req ? in_data_i[win_idx] : '0;

  fifo_v3 #(
    .DATA_WIDTH (IdxW),
    .DEPTH      (MaxOutstanding)
  ) i_id_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .full_o  (q_full),
    .empty_o (q_empty),
    .data_i  (win_idx),
    .push_i  (hs),
    .data_o  (head),
    .pop_i   (pop)
  );

  assign pop          = out_r_valid_i & ~q_empty;
  assign in_r_valid_o = pop ? (NrReq'(1) << head) : '0;
  assign in_r_data_o  = out_r_data_i;

  // A response with nothing outstanding means state was lost (e.g. reset mid-flight).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      err_q <= 1'b0;
    else if (clear_i)                 err_q <= 1'b0;
    else if (out_r_valid_i & q_empty) err_q <= 1'b1;
  end
  assign err_o = err_q;

`ifdef SNITCH_HWPE_TCDM_ARB_PERF_EN
  for (genvar i = 0; i < NrReq; i++) begin : gen_perf
    perf_cnt_t gnt_q, stall_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        gnt_q   <= '0;
        stall_q <= '0;
      end else if (clear_i) begin
        gnt_q   <= '0;
        stall_q <= '0;
      end else begin
        if (in_gnt_o[i] && gnt_q != PerfCntMax) gnt_q <= gnt_q + 1'b1;
        if (in_req_i[i] && !in_gnt_o[i] && stall_q != PerfCntMax) stall_q <= stall_q + 1'b1;
      end
    end
    assign perf_gnt_o[i]   = gnt_q;
    assign perf_stall_o[i] = stall_q;
  end
`else
  assign perf_gnt_o   = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_snitch_hwpe_tcdm_arbiter.sv
// Directed bench for the HWPE TCDM arbiter: arbitration, lock, queue limits, routing, err, perf.
module tb_snitch_hwpe_tcdm_arbiter;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic [1:0]        req = '0;
  logic [1:0]        gnt;
  logic [1:0][31:0]  add = '0;
  logic [1:0]        wen = '0;
  logic [1:0][31:0]  be = '0;
  logic [1:0][255:0] data = '0;
  logic [1:0]        r_valid;
  logic [255:0]      r_data;
  logic              out_req;
  logic              out_gnt = 1'b0;
  logic [31:0]       out_add;
  logic              out_wen;
  logic [31:0]       out_be;
  logic [255:0]      out_data;
  logic              out_r_valid = 1'b0;
  logic [255:0]      out_r_data = '0;
  logic              err;
  logic [1:0][31:0]  perf_gnt, perf_stall;

  int checks = 0;
  int failures = 0;

`ifdef SNITCH_HWPE_TCDM_ARB_PERF_EN
  localparam logic [31:0] ExpStall1 = 32'd3;
  localparam logic [31:0] ExpGnt1   = 32'd1;
`else
  localparam logic [31:0] ExpStall1 = 32'd0;
  localparam logic [31:0] ExpGnt1   = 32'd0;
`endif

  snitch_hwpe_tcdm_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .in_req_i      (req),
    .in_gnt_o      (gnt),
    .in_add_i      (add),
    .in_wen_i      (wen),
    .in_be_i       (be),
    .in_data_i     (data),
    .in_r_valid_o  (r_valid),
    .in_r_data_o   (r_data),
    .out_req_o     (out_req),
    .out_gnt_i     (out_gnt),
    .out_add_o     (out_add),
    .out_wen_o     (out_wen),
    .out_be_o      (out_be),
    .out_data_o    (out_data),
    .out_r_valid_i (out_r_valid),
    .out_r_data_i  (out_r_data),
    .err_o         (err),
    .perf_gnt_o    (perf_gnt),
    .perf_stall_o  (perf_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(r_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_perf", 64'(perf_gnt[0] | perf_gnt[1] | perf_stall[0] | perf_stall[1]), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    add[0] = 32'h100; add[1] = 32'h200;
    wen = 2'b01;
    be[0] = 32'h0000_FFFF; be[1] = 32'hFFFF_0000;
    data[0][63:0] = 64'hA0A0; data[1][63:0] = 64'hB1B1;
    out_r_data[63:0] = 64'hDEAD_BEEF;

    // 1: both requesting, always granted, 1-cycle responses
    @(negedge clk); req = 2'b11; out_gnt = 1'b1; #1;
    chk("t1_gnt_a", 64'(gnt), 64'b01);
    chk("t1_add_a", 64'(out_add), 64'h100);
    chk("t1_wen_a", 64'(out_wen), 64'd1);
    chk("t1_be_a", 64'(out_be), 64'h0000_FFFF);
    @(negedge clk); out_r_valid = 1'b1; #1;
    chk("t1_gnt_b", 64'(gnt), 64'b10);
    chk("t1_add_b", 64'(out_add), 64'h200);
    chk("t1_wen_b", 64'(out_wen), 64'd0);
    chk("t1_data_b", out_data[63:0], 64'hB1B1);
    chk("t1_rv_b", 64'(r_valid), 64'b01);
    chk("t1_rdata", r_data[63:0], 64'hDEAD_BEEF);
    @(negedge clk); #1;
    chk("t1_gnt_c", 64'(gnt), 64'b01);
    chk("t1_rv_c", 64'(r_valid), 64'b10);
    @(negedge clk); #1;
    chk("t1_gnt_d", 64'(gnt), 64'b10);
    chk("t1_rv_d", 64'(r_valid), 64'b01);
    @(negedge clk); req = 2'b00; #1;
    chk("t1_idle_req", 64'(out_req), 64'd0);
    chk("t1_rv_e", 64'(r_valid), 64'b10);
    @(negedge clk); out_r_valid = 1'b0; #1;
    chk("t1_err", 64'(err), 64'd0);

    // 2: move rr pointer to 1, then stall req0 and raise req1 behind it
    @(negedge clk); req = 2'b01; out_gnt = 1'b1; #1;
    chk("t2_pre_gnt", 64'(gnt), 64'b01);
    @(negedge clk); req = 2'b00; out_r_valid = 1'b1; #1;
    chk("t2_pre_rv", 64'(r_valid), 64'b01);
    @(negedge clk); out_r_valid = 1'b0; req = 2'b01; out_gnt = 1'b0; #1;
    chk("t2_req", 64'(out_req), 64'd1);
    chk("t2_nogt0", 64'(gnt), 64'd0);
    chk("t2_add0", 64'(out_add), 64'h100);
    @(negedge clk); req = 2'b11; #1;
    chk("t2_lock1", 64'(out_add), 64'h100);
    chk("t2_nogt1", 64'(gnt), 64'd0);
    @(negedge clk); #1;
    chk("t2_lock2", 64'(out_add), 64'h100);
    @(negedge clk); out_gnt = 1'b1; #1;
    chk("t2_gnt0", 64'(gnt), 64'b01);
    chk("t2_add3", 64'(out_add), 64'h100);
    @(negedge clk); req = 2'b10; #1;
    chk("t2_gnt1", 64'(gnt), 64'b10);
    chk("t2_add4", 64'(out_add), 64'h200);
    @(negedge clk); req = 2'b00; out_r_valid = 1'b1; #1;
    chk("t2_rv0", 64'(r_valid), 64'b01);
    @(negedge clk); #1;
    chk("t2_rv1", 64'(r_valid), 64'b10);
    @(negedge clk); out_r_valid = 1'b0;

    // 3: queue depth 4 with no responses
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); req = 2'b01; out_gnt = 1'b1; #1;
      chk($sformatf("t3_gnt%0d", k), 64'(gnt), 64'b01);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t3_full_req%0d", k), 64'(out_req), 64'd0);
      chk($sformatf("t3_full_gnt%0d", k), 64'(gnt), 64'd0);
    end
    @(negedge clk); out_r_valid = 1'b1; #1;
    chk("t3_nobypass", 64'(out_req), 64'd0);
    chk("t3_rv_pop", 64'(r_valid), 64'b01);
    @(negedge clk); out_r_valid = 1'b0; #1;
    chk("t3_refill_req", 64'(out_req), 64'd1);
    chk("t3_refill_gnt", 64'(gnt), 64'b01);
    @(negedge clk); req = 2'b00; out_r_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1; chk($sformatf("t3_drain%0d", k), 64'(r_valid), 64'b01);
      @(negedge clk);
    end
    out_r_valid = 1'b0; #1;
    chk("t3_err", 64'(err), 64'd0);

    // 4: owners 0,1,1,0 answered 5 cycles later in the same order
    @(negedge clk); req = 2'b01; #1; chk("t4_g0", 64'(gnt), 64'b01);
    @(negedge clk); req = 2'b10; #1; chk("t4_g1", 64'(gnt), 64'b10);
    @(negedge clk); req = 2'b10; #1; chk("t4_g2", 64'(gnt), 64'b10);
    @(negedge clk); req = 2'b01; #1; chk("t4_g3", 64'(gnt), 64'b01);
    @(negedge clk); req = 2'b00;
    @(negedge clk); out_r_valid = 1'b1; #1; chk("t4_rv0", 64'(r_valid), 64'b01);
    @(negedge clk); #1; chk("t4_rv1", 64'(r_valid), 64'b10);
    @(negedge clk); #1; chk("t4_rv2", 64'(r_valid), 64'b10);
    @(negedge clk); #1; chk("t4_rv3", 64'(r_valid), 64'b01);
    @(negedge clk); out_r_valid = 1'b0; #1;
    chk("t4_err", 64'(err), 64'd0);

    // 5: stray response sets sticky err, clear_i drops it and resets rr
    @(negedge clk); out_r_valid = 1'b1; #1;
    chk("t5_rv_drop", 64'(r_valid), 64'd0);
    @(negedge clk); out_r_valid = 1'b0; #1;
    chk("t5_err_set", 64'(err), 64'd1);
    @(negedge clk); #1;
    chk("t5_err_hold", 64'(err), 64'd1);
    @(negedge clk); clear = 1'b1; req = 2'b11; out_gnt = 1'b1; #1;
    chk("t5_clr_gnt", 64'(gnt), 64'd0);
    chk("t5_clr_req", 64'(out_req), 64'd0);
    @(negedge clk); clear = 1'b0; #1;
    chk("t5_err_clr", 64'(err), 64'd0);
    chk("t5_rr_zero", 64'(gnt), 64'b01);
    @(negedge clk); req = 2'b00; out_r_valid = 1'b1; #1;
    chk("t5_rv", 64'(r_valid), 64'b01);
    @(negedge clk); out_r_valid = 1'b0;

    // 6: req1 stalled 3 cycles, granted on the 4th
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0; req = 2'b10; out_gnt = 1'b0; #1;
    chk("t6_stall0", 64'(gnt), 64'd0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t6_stall2", 64'(gnt), 64'd0);
    @(negedge clk); out_gnt = 1'b1; #1;
    chk("t6_gnt", 64'(gnt), 64'b10);
    @(negedge clk); req = 2'b00; out_gnt = 1'b0; out_r_valid = 1'b1; #1;
    chk("t6_perf_stall1", 64'(perf_stall[1]), 64'(ExpStall1));
    chk("t6_perf_gnt1", 64'(perf_gnt[1]), 64'(ExpGnt1));
    chk("t6_perf_gnt0", 64'(perf_gnt[0]), 64'd0);
    chk("t6_perf_stall0", 64'(perf_stall[0]), 64'd0);
    chk("t6_rv", 64'(r_valid), 64'b10);
    @(negedge clk); out_r_valid = 1'b0;

    // 7: reset with a request in flight; its late response flags err
    @(negedge clk); req = 2'b01; out_gnt = 1'b1; #1;
    chk("t7_gnt", 64'(gnt), 64'b01);
    @(negedge clk); req = 2'b00; out_gnt = 1'b0; rst_n = 1'b0; #1;
    chk("t7_rst_err", 64'(err), 64'd0);
    chk("t7_rst_perf", 64'(perf_stall[1]), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); out_r_valid = 1'b1; #1;
    chk("t7_rv_drop", 64'(r_valid), 64'd0);
    @(negedge clk); out_r_valid = 1'b0; #1;
    chk("t7_err", 64'(err), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
